// File: rtl/dcsk_rx_pkg.sv
// Shared types and defaults for the DCSK receive-side deserializer.
package dcsk_rx_pkg;

  // Bit assembler states
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } deser_state_t;

  localparam int DESER_WORD_W     = 8;
  localparam int DESER_FIFO_DEPTH = 4;

endpackage

// File: rtl/dcsk_sync_fifo.sv
// Small synchronous FIFO with registered count; storage resets to zero so
// the head word is always X-free. A pop in the same cycle frees room for a push.
module dcsk_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wptr, rptr;
  logic                    do_pop, do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcsk_rx_deserializer.sv
// Packs demodulated bits into WORD_W-bit words and queues them for a
// valid/ready consumer. Define DCSK_RX_DESER_MSB_FIRST_EN to place the first
// received bit in the word MSB instead of the LSB.
module dcsk_rx_deserializer
  import dcsk_rx_pkg::*;
#(
  parameter int WORD_W     = DESER_WORD_W,
  parameter int FIFO_DEPTH = DESER_FIFO_DEPTH,
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Bit_In,
  input  logic              Bit_Valid,
  input  logic              Flush,
  input  logic              Ovf_Clr,
  output logic [WORD_W-1:0] Data_Out,
  output logic              Data_Valid,
  input  logic              Data_Ready,
  output logic [FCW-1:0]    Fifo_Count,
  output logic              Busy,
  output logic              Overflow
);

  localparam int CW = $clog2(WORD_W + 1);

  deser_state_t      state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [WORD_W-1:0] sh, sh_nxt, sh_shift;
  logic              done, full, empty, pop, drop;

`ifdef DCSK_RX_DESER_MSB_FIRST_EN
  assign sh_shift = {sh[WORD_W-2:0], Bit_In};
`else
  assign sh_shift = {Bit_In, sh[WORD_W-1:1]};
`endif

  // Assembler state register with shift register and bit count
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
    end
  end

  // Next-state: Flush beats a simultaneous strobe; last bit completes the word
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    done      = 1'b0;
    if (Flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      sh_nxt    = '0;
    end else if (Bit_Valid) begin
      case (state)
        S_IDLE, S_COLLECT: begin
          if (cnt == CW'(WORD_W - 1)) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            sh_nxt    = '0;
          end else begin
            state_nxt = S_COLLECT;
            cnt_nxt   = cnt + 1'b1;
            sh_nxt    = sh_shift;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign Busy       = (state == S_COLLECT);
  assign Data_Valid = ~empty;
  assign pop        = ~empty & Data_Ready;
  assign drop       = done & full & ~pop;

  // The completed word is the shift register plus the bit arriving this cycle
  dcsk_sync_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (done),
    .wdata (sh_shift),
    .pop   (pop),
    .rdata (Data_Out),
    .full  (full),
    .empty (empty),
    .count (Fifo_Count)
  );

  // Sticky overflow; a clear in the same cycle as a drop wins
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)          Overflow <= 1'b0;
    else if (Ovf_Clr) Overflow <= 1'b0;
    else if (drop)    Overflow <= 1'b1;
  end

endmodule

// File: tb/tb_dcsk_rx_deserializer.sv
// Scoreboard bench for dcsk_rx_deserializer: the driver keeps a word-level
// model and queues expected words; a monitor checks every handshake.
module tb_dcsk_rx_deserializer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Bit_In = 1'b0, Bit_Valid = 1'b0, Flush = 1'b0, Ovf_Clr = 1'b0, Data_Ready = 1'b0;
  logic [W-1:0]  Data_Out;
  logic          Data_Valid, Busy, Overflow;
  logic [CW-1:0] Fifo_Count;

  dcsk_rx_deserializer #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .Clk(Clk), .Rst(Rst), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid), .Flush(Flush),
    .Ovf_Clr(Ovf_Clr), .Data_Out(Data_Out), .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready), .Fifo_Count(Fifo_Count), .Busy(Busy), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_err = 0;

  // model state
  logic [W-1:0] exp_q[$];
  bit           bits_q[$];
  int           m_cnt = 0;
  bit           m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
`ifdef DCSK_RX_DESER_MSB_FIRST_EN
      w[W-1-i] = bits_q[i];
`else
      w[i] = bits_q[i];
`endif
    end
    return w;
  endfunction

  // Word-level model of one clock edge given the inputs applied in that cycle
  task automatic model_step(input bit bv, input bit b, input bit fl, input bit oc, input bit rdy);
    bit pop, done, acc, drop;
    logic [W-1:0] w;
    pop = (m_cnt > 0) && rdy;
    done = 0; acc = 0; drop = 0; w = '0;
    if (fl) bits_q.delete();
    else if (bv) begin
      bits_q.push_back(b);
      if (bits_q.size() == W) begin
        w = build_word();
        done = 1;
        bits_q.delete();
      end
    end
    if (done) begin
      if (m_cnt < D || pop) begin acc = 1; exp_q.push_back(w); end
      else drop = 1;
    end
    m_cnt = m_cnt + int'(acc) - int'(pop);
    if (oc) m_ovf = 0;
    else if (drop) m_ovf = 1;
  endtask

  // One cycle: check state after the last edge, then drive and model this cycle
  task automatic cyc(input bit bv, input bit b, input bit fl, input bit oc, input bit rdy);
    @(posedge Clk); #1;
    chk("fifo_count", Fifo_Count, m_cnt);
    chk("data_valid", Data_Valid, m_cnt != 0);
    chk("busy", Busy, bits_q.size() != 0);
    chk("overflow", Overflow, m_ovf);
    Bit_Valid = bv; Bit_In = b; Flush = fl; Ovf_Clr = oc; Data_Ready = rdy;
    model_step(bv, b, fl, oc, rdy);
  endtask

  task automatic send_word(input bit rdy);
    for (int i = 0; i < W; i++) cyc(1, 1'($urandom), 0, 0, rdy);
  endtask

  task automatic drain();
    int guard = 0;
    while (m_cnt != 0 && guard < 4 * D) begin cyc(0, 0, 0, 0, 1); guard++; end
    if (m_cnt != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: model count %0d after %0d cycles", m_cnt, guard);
    end
    cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: every accepted word must be the oldest expected one
  always @(negedge Clk) begin
    if (!Rst && Data_Valid && Data_Ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", Data_Out, $time);
      end else begin
        chk("data_out", Data_Out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] pat;
    pat = 8'b1000_1101; // bits sent in order pat[0]..pat[7] = 1,0,1,1,0,0,0,1
    #12;
    chk("reset_data_out", Data_Out, 0);
    chk("reset_valid", Data_Valid, 0);
    chk("reset_count", Fifo_Count, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_ovf", Overflow, 0);
    @(posedge Clk); #1 Rst = 1'b0;

    // Known pattern
    for (int i = 0; i < 8; i++) cyc(1, pat[i], 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
`ifdef DCSK_RX_DESER_MSB_FIRST_EN
    chk("pattern_word", Data_Out, 8'hB1);
`else
    chk("pattern_word", Data_Out, 8'h8D);
`endif
    chk("pattern_count", Fifo_Count, 1);
    drain();

    // Overflow: five words into a four-deep FIFO with no consumer
    for (int k = 0; k < 5; k++) send_word(0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_count", Fifo_Count, 4);
    chk("ovf_flag", Overflow, 1);
    drain();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_cleared", Overflow, 0);

    // Full FIFO, consumer pops in the completion cycle
    for (int k = 0; k < 4; k++) send_word(0);
    for (int i = 0; i < W - 1; i++) cyc(1, 1'($urandom), 0, 0, 0);
    cyc(1, 1'($urandom), 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("full_pop_count", Fifo_Count, 4);
    chk("full_pop_ovf", Overflow, 0);
    drain();

    // Flush beats a simultaneous strobe
    for (int i = 0; i < 3; i++) cyc(1, 1'($urandom), 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("flush_busy", Busy, 0);
    chk("flush_count", Fifo_Count, 0);
    send_word(0);
    drain();

    // Asynchronous reset with words queued and a partial word
    send_word(0); send_word(0);
    for (int i = 0; i < 5; i++) cyc(1, 1'($urandom), 0, 0, 0);
    @(posedge Clk); #1;
    Bit_Valid = 0; Flush = 0; Ovf_Clr = 0; Data_Ready = 0;
    #2 Rst = 1'b1;
    #1;
    chk("rst_count", Fifo_Count, 0);
    chk("rst_valid", Data_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_data", Data_Out, 0);
    exp_q.delete(); bits_q.delete(); m_cnt = 0; m_ovf = 0;
    @(posedge Clk); #1 Rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 800; n++)
      cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 49) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
    cyc(0, 0, 1, 0, 0);
    drain();
    chk("leftover_words", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
